load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Responder side of the data-memory control interface: consumes MemRead/MemWrite plus funct3, address and store data, and executes the access on a simple req/ready/rvalid data bus.
- Stalls the pipeline while an access is in flight and returns an aligned, sign- or zero-extended load result for writeback.
- Sits in the MEM stage, between the control/ALU outputs and the data bus.

Parameters:
- BUS_TIMEOUT, 255, max cycles spent in REQ plus WAIT before the access is aborted; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- MemRead_i  in  1  load request from control
- MemWrite_i  in  1  store request from control
- funct3_i  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold pipeline
- rdata_o  out  32  extended load data, registered
- misaligned_o  out  1  misaligned access rejected
- illegal_o  out  1  bad funct3, or MemRead and MemWrite both high
- bus_err_o  out  1  timeout abort pulse
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address, {addr[31:2],2'b00}
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_ready_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data

Behaviour:
- Reset: state IDLE; timeout counter 0; every output 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no request: stall_o=0.
- IDLE, valid request: stall_o=1 (combinational). Register we, word address, be and wdata, then go to REQ.
- IDLE, rejected request: no state change, no bus activity, stall_o=0. misaligned_o or illegal_o is high (combinational) for that cycle.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal: MemRead_i and MemWrite_i both high; load funct3 of 011/110/111; store funct3 >= 011.
  - Illegal takes priority over misaligned.
- REQ: bus_req_o=1 with stable registered fields; stall_o=1.
  - On bus_ready_i: a write goes to DONE; a read goes to WAIT.
- WAIT: stall_o=1. bus_rvalid_i captures the lane-extracted, extended bus_rdata_i into rdata_o, then go to DONE.
  - bus_rvalid_i is ignored in every other state.
- DONE: stall_o=0 for exactly one cycle; go to IDLE unconditionally. Inputs (still the old instruction) are ignored, so there is no re-issue.
- Latency:
  - Write with ready on the first REQ cycle: 2 stall cycles.
  - Read with ready immediately and rvalid one cycle later: 3 stall cycles.
  - Each extra wait cycle adds one.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
  - Loads drive the same be.
- Store data: B={4{wdata[7:0]}}; H={2{wdata[15:0]}}; W=wdata.
- Load extract: byte at bus_rdata_i[8*addr[1:0]+:8]; half at [16*addr[1]+:16]. B/H sign-extend; BU/HU zero-extend.
- rdata_o holds its value until the next load completes. Stores and rejects do not change it.
- Timeout (BUS_TIMEOUT>0):
  - The counter increments each cycle in REQ or WAIT and clears on entry to REQ.
  - When it reaches BUS_TIMEOUT: bus_err_o=1 for one cycle, drop to DONE, rdata_o=0.
- Reset mid-access: next state IDLE, bus_req_o=0, and a late rvalid is ignored.

Test Plan:
- LW addr 0x100: ready on 1st REQ cycle, rvalid next cycle with 0xDEADBEEF -> bus_addr 0x100, be 1111, stall high 3 cycles, rdata_o=0xDEADBEEF in DONE.
- LB addr 0x103 returning 0x80FF_FF00 -> be 1000, rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x12345678, ready delayed 3 cycles -> be 0010, bus_wdata 0x78787878, bus_we=1, fields stable during the wait, stall 5 cycles.
- LW addr 0x102 -> misaligned_o=1 for 1 cycle, no bus_req_o, stall_o=0. MemRead and MemWrite both high -> illegal_o=1.
- BUS_TIMEOUT=4, read request with ready never asserted -> bus_err_o pulses after 4 REQ cycles, DONE, rdata_o=0. A later rvalid is ignored.
- rst_i in WAIT, then rvalid the following cycle -> IDLE, all outputs 0, rdata_o stays 0. A next back-to-back SW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store responder. Accepts MemRead/MemWrite from
//            control, runs the access on a req/ready/rvalid data bus, stalls
//            the pipeline meanwhile and returns an extended load result.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Counter only needs to hold 0..BUS_TIMEOUT-1
  localparam int c_TMO_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int c_TMO_LAST = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST_V = c_TMO_W'(c_TMO_LAST);

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_TMO_W-1:0] r_tmoCnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [1:0]         r_byteOff;
  logic [31:0]        r_busAddr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_busErr;

  logic        w_anyReq;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdataRep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic        w_tmoHit;
  logic        w_tmoAbort;

  assign w_anyReq = MemRead_i | MemWrite_i;

  // Request legality: illegal encodings win over misalignment
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (w_anyReq) begin
      if (MemRead_i && MemWrite_i) begin
        w_illegal = 1'b1;
      end else if (MemRead_i) begin
        w_illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end else begin
        w_illegal = (funct3_i >= 3'b011);
      end
      if (!w_illegal) begin
        case (funct3_i[1:0])
          2'b01:   w_misaligned = addr_i[0];
          2'b10:   w_misaligned = |addr_i[1:0];
          default: w_misaligned = 1'b0;
        endcase
      end
    end
  end

  assign w_accept = !rst_i && (r_state == c_IDLE) && w_anyReq && !w_illegal && !w_misaligned;

  // Byte-lane enables and lane-replicated store data for the incoming request
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        w_be       = 4'b0001 << addr_i[1:0];
        w_wdataRep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be       = 4'b0011 << addr_i[1:0];
        w_wdataRep = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be       = 4'b1111;
        w_wdataRep = wdata_i;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word
  assign w_byte = bus_rdata_i[{r_byteOff, 3'b000} +: 8];
  assign w_half = bus_rdata_i[{r_byteOff[1], 4'b0000} +: 16];

  always_comb begin
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'd0, w_byte};
      3'b101:  w_loadData = {16'd0, w_half};
      default: w_loadData = bus_rdata_i;
    endcase
  end

  assign w_tmoHit   = (BUS_TIMEOUT != 0) && (r_tmoCnt == c_TMO_LAST_V);
  assign w_tmoAbort = w_tmoHit && (((r_state == c_REQ) && !bus_ready_i) ||
                                   ((r_state == c_WAIT) && !bus_rvalid_i));

  // Next-state selection; a completing handshake beats a same-cycle timeout
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_nextState = c_REQ;
      c_REQ: begin
        if (bus_ready_i)     w_nextState = r_we ? c_DONE : c_WAIT;
        else if (w_tmoHit)   w_nextState = c_DONE;
      end
      c_WAIT: begin
        if (bus_rvalid_i)    w_nextState = c_DONE;
        else if (w_tmoHit)   w_nextState = c_DONE;
      end
      default:               w_nextState = c_IDLE;
    endcase
  end

  // State, captured request fields, timeout counter and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= c_IDLE;
      r_tmoCnt  <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_byteOff <= 2'b00;
      r_busAddr <= 32'd0;
      r_be      <= 4'b0000;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_busErr  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_busErr <= w_tmoAbort;
      if (w_accept) begin
        r_we      <= MemWrite_i;
        r_funct3  <= funct3_i;
        r_byteOff <= addr_i[1:0];
        r_busAddr <= {addr_i[31:2], 2'b00};
        r_be      <= w_be;
        r_wdata   <= w_wdataRep;
        r_tmoCnt  <= '0;
      end else if ((r_state == c_REQ) || (r_state == c_WAIT)) begin
        r_tmoCnt <= r_tmoCnt + c_TMO_W'(1);
      end
      if ((r_state == c_WAIT) && bus_rvalid_i) begin
        r_rdata <= w_loadData;
      end else if (w_tmoAbort) begin
        r_rdata <= 32'd0;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted
  assign stall_o      = !rst_i && (w_accept || (r_state == c_REQ) || (r_state == c_WAIT));
  assign illegal_o    = !rst_i && (r_state == c_IDLE) && w_illegal;
  assign misaligned_o = !rst_i && (r_state == c_IDLE) && w_misaligned;
  assign bus_req_o    = !rst_i && (r_state == c_REQ);
  assign bus_err_o    = r_busErr;
  assign bus_we_o     = r_we;
  assign bus_addr_o   = r_busAddr;
  assign bus_be_o     = r_be;
  assign bus_wdata_o  = r_wdata;
  assign rdata_o      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a bus responder and
//            a behavioural model of legality, lanes, extension and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, misaligned, illegal, busErr, busReq, busWe;
  logic [31:0] rdata, busAddr, busWdata, busRdata;
  logic [3:0]  busBe;
  logic        busReady, busRvalid;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdlRdata = 32'd0;

  load_store_unit #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(MemRead), .MemWrite_i(MemWrite), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .rdata_o(rdata), .misaligned_o(misaligned),
    .illegal_o(illegal), .bus_err_o(busErr),
    .bus_req_o(busReq), .bus_we_o(busWe), .bus_addr_o(busAddr),
    .bus_be_o(busBe), .bus_wdata_o(busWdata),
    .bus_ready_i(busReady), .bus_rvalid_i(busRvalid), .bus_rdata_i(busRdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic isIllegal(input logic rd, input logic wr, input logic [2:0] f);
    if (rd && wr) return 1'b1;
    if (rd)       return !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (wr)       return f > 3'd2;
    return 1'b0;
  endfunction

  function automatic logic [3:0] expBe(input logic [2:0] f, input logic [31:0] a);
    int n = sizeOf(f);
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    int n = sizeOf(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // One pipeline access; the bench acts as bus responder with given delays
  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdyDly, input int rvDly, input logic [31:0] d,
                          input string tag);
    logic ill, mis, isRead, tmoExp, done, inWait, waitNext;
    int   stalls, reqN, waitN, expStalls;
    ill    = isIllegal(rd, wr, f);
    mis    = (rd || wr) && !ill && ((a % sizeOf(f)) != 0);
    isRead = rd && !wr;
    tmoExp = rdyDly >= TMO;
    expStalls = tmoExp ? 1 + TMO : 2 + rdyDly + (isRead ? rvDly + 1 : 0);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; funct3 = f; addr = a; wdata = wd;
    busReady = 1'b0; busRvalid = 1'b0;
    #1;
    check({tag, ":illegal"}, 64'(illegal), 64'(ill));
    check({tag, ":misaligned"}, 64'(misaligned), 64'(mis));
    if (ill || mis || !(rd || wr)) begin
      check({tag, ":rejStall"}, 64'(stall), 64'd0);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      check({tag, ":rejNoReq"}, {62'd0, busReq, stall}, 64'd0);
      check({tag, ":rejRdata"}, 64'(rdata), 64'(mdlRdata));
      return;
    end
    stalls = 0; reqN = 0; waitN = 0; done = 1'b0; waitNext = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      inWait   = waitNext;
      waitNext = 1'b0;
      if (stall) begin
        stalls++;
      end else if (c > 0) begin
        done = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; busReady = 1'b0; busRvalid = 1'b0;
        if (isRead) mdlRdata = tmoExp ? 32'd0 : expLoad(f, a, d);
        check({tag, ":stallCycles"}, 64'(stalls), 64'(expStalls));
        check({tag, ":rdata"}, 64'(rdata), 64'(mdlRdata));
        check({tag, ":busErr"}, 64'(busErr), 64'(tmoExp));
        check({tag, ":doneNoReq"}, 64'(busReq), 64'd0);
      end
      if (!done) begin
        if (busReq) begin
          reqN++;
          check({tag, ":busFields"}, {27'd0, busWe, busAddr, busBe},
                {27'd0, !isRead, a & 32'hFFFF_FFFC, expBe(f, a)});
          if (!isRead) check({tag, ":busWdata"}, 64'(busWdata), 64'(expWdata(f, wd)));
          busReady = (reqN > rdyDly);
          waitNext = busReady && isRead;
        end else begin
          busReady = 1'b0;
        end
        if (inWait) begin
          waitN++;
          busRvalid = (waitN > rvDly);
          busRdata  = busRvalid ? d : $urandom;
          waitNext  = !busRvalid;
        end else begin
          // rvalid noise outside WAIT must be ignored
          busRvalid = 1'($urandom % 2);
          busRdata  = $urandom;
        end
      end
    end
    if (!done) check({tag, ":hang"}, 64'd1, 64'd0);
  endtask

  initial begin
    logic [2:0] legalF [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic       rd, wr;
    logic [2:0] f;
    int         sel;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; busReady = 1'b0; busRvalid = 1'b0; busRdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset:outputs", {stall, misaligned, illegal, busErr, busReq, busWe, busBe, 54'd0},
          64'd0);
    check("reset:data", {busAddr, rdata | busWdata}, 64'd0);
    rst = 1'b0;

    // Directed accesses
    doAccess(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, "LW");
    doAccess(1, 0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FFFF00, "LB");
    doAccess(1, 0, 3'd4, 32'h103, 32'h0, 1, 2, 32'h80FFFF00, "LBU");
    doAccess(1, 0, 3'd5, 32'h102, 32'h0, 0, 1, 32'h80FFFF00, "LHU");
    doAccess(0, 1, 3'd0, 32'h201, 32'h12345678, 3, 0, 32'h0, "SB");
    doAccess(0, 1, 3'd1, 32'h202, 32'hCAFEBABE, 0, 0, 32'h0, "SH");
    doAccess(1, 0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0, "LWmis");
    doAccess(1, 1, 3'd2, 32'h100, 32'h0, 0, 0, 32'h0, "RW");
    doAccess(1, 1, 3'd1, 32'h101, 32'h0, 0, 0, 32'h0, "RWmis");
    doAccess(0, 1, 3'd4, 32'h100, 32'h0, 0, 0, 32'h0, "SBU");

    // Timeout: ready never arrives, then a stray rvalid must not land
    doAccess(1, 0, 3'd2, 32'h400, 32'h0, 1000, 0, 32'h11111111, "TMO");
    @(negedge clk);
    busRvalid = 1'b1; busRdata = 32'h5A5A5A5A;
    #1;
    check("tmoLate:idle", {62'd0, busReq, stall}, 64'd0);
    @(negedge clk);
    busRvalid = 1'b0;
    #1;
    check("tmoLate:rdata", 64'(rdata), 64'd0);
    check("tmoLate:err", 64'(busErr), 64'd0);

    // Reset while waiting for read data
    doAccess(1, 0, 3'd2, 32'h500, 32'h0, 0, 0, 32'h76543210, "preRst");
    @(negedge clk);
    MemRead = 1'b1; funct3 = 3'd2; addr = 32'h600;
    @(negedge clk);
    busReady = 1'b1;
    @(negedge clk);
    busReady = 1'b0; MemRead = 1'b0; rst = 1'b1;
    #1;
    check("rstWait:comb", {62'd0, busReq, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0; busRvalid = 1'b1; busRdata = 32'hCAFEF00D;
    #1;
    check("rstWait:outputs", {stall, misaligned, illegal, busErr, busReq, busWe, busBe, 54'd0},
          64'd0);
    check("rstWait:data", {busAddr, rdata | busWdata}, 64'd0);
    @(negedge clk);
    busRvalid = 1'b0;
    #1;
    mdlRdata = 32'd0;
    check("rstWait:lateRvalid", 64'(rdata), 64'd0);
    doAccess(0, 1, 3'd2, 32'h700, 32'hA5A5F00F, 0, 0, 32'h0, "SWafterRst");
    doAccess(0, 1, 3'd2, 32'h704, 32'h0F0F1234, 1, 0, 32'h0, "SWb2b");

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      sel = $urandom % 10;
      rd  = (sel < 4) || (sel == 8);
      wr  = ((sel >= 4) && (sel < 8)) || (sel == 8);
      f   = ($urandom % 4 != 0) ? legalF[$urandom % 5] : 3'($urandom);
      doAccess(rd, wr, f, $urandom, $urandom, $urandom % 4, $urandom % 4, $urandom, "RND");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
